// File: rtl/spi_stream_tx.sv
// Sample buffer streamed out over an SPI mode-0 master, one chip-select frame per word,
// with an inclusive wrapping address range, loop mode, graceful stop and a fixed inter-word gap.
module spi_stream_tx #(
  parameter int unsigned DATA_W            = 16,
  parameter int unsigned ADDR_W            = 8,
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned GAP_CYCLES        = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [15:0]       word_cnt,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);
  localparam int unsigned DEPTH        = 2**ADDR_W;
  localparam int unsigned SHIFT_CYCLES = 2 * CLKS_PER_HALF_BIT * DATA_W;
  localparam int unsigned CNT_MAX      = (SHIFT_CYCLES > GAP_CYCLES) ? SHIFT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);
  localparam int unsigned HC_W         = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [HC_W-1:0]   hcnt, hcnt_d;
  logic [ADDR_W-1:0] first_addr, first_addr_d, last_addr, last_addr_d, cur_addr_d;
  logic              loop_mode, loop_mode_d, stop_req, stop_req_d;
  logic              busy_d, done_d, sclk_d, cs_n_d;
  logic [15:0]       word_cnt_d;
  logic              load, shift;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port lands directly in the shift register so the MSB is on mosi in the first SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        shreg <= '0;
    else if (load)  shreg <= mem[cur_addr];
    else if (shift) shreg <= {shreg[DATA_W-2:0], 1'b0};
  end

  assign mosi = shreg[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      first_addr <= '0;
      last_addr  <= '0;
      loop_mode  <= 1'b0;
      stop_req   <= 1'b0;
      cur_addr   <= '0;
      word_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      hcnt       <= hcnt_d;
      first_addr <= first_addr_d;
      last_addr  <= last_addr_d;
      loop_mode  <= loop_mode_d;
      stop_req   <= stop_req_d;
      cur_addr   <= cur_addr_d;
      word_cnt   <= word_cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      sclk       <= sclk_d;
      cs_n       <= cs_n_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    hcnt_d       = hcnt;
    first_addr_d = first_addr;
    last_addr_d  = last_addr;
    loop_mode_d  = loop_mode;
    stop_req_d   = stop_req;
    cur_addr_d   = cur_addr;
    word_cnt_d   = word_cnt;
    done_d       = 1'b0;
    sclk_d       = sclk;
    cs_n_d       = cs_n;
    load         = 1'b0;
    shift        = 1'b0;

    case (state)
      IDLE: begin
        stop_req_d = 1'b0;
        if (start && !stop) begin
          first_addr_d = start_addr;
          last_addr_d  = end_addr;
          loop_mode_d  = loop_en;
          cur_addr_d   = start_addr;
          word_cnt_d   = '0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        cnt_d   = '0;
        hcnt_d  = '0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt + CNT_W'(1);
        // Shift on the falling sclk edge so mosi is stable across each rising edge.
        if (hcnt == HC_W'(CLKS_PER_HALF_BIT - 1)) begin
          hcnt_d = '0;
          sclk_d = ~sclk;
          shift  = sclk;
        end else begin
          hcnt_d = hcnt + HC_W'(1);
        end
        if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
          cnt_d   = '0;
          shift   = 1'b0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b1;
          state_d = GAP;
          if (word_cnt != 16'hFFFF) word_cnt_d = word_cnt + 16'd1;
        end
      end
      GAP: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (stop || stop_req) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (cur_addr != last_addr) begin
            cur_addr_d = cur_addr + ADDR_W'(1);
            state_d    = FETCH;
          end else if (loop_mode) begin
            cur_addr_d = first_addr;
            state_d    = FETCH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stop seen anywhere in a run is remembered until the next gap decision.
    if (state != IDLE && stop) stop_req_d = 1'b1;
    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_spi_stream_tx.sv
// Directed bench for spi_stream_tx: a negedge SPI monitor records frames and done pulses,
// scenario tasks compare them against hand-computed expectations.
module tb_spi_stream_tx;
  logic        clk, rst, wr_en, loop_en, start, stop;
  logic [7:0]  wr_addr, start_addr, end_addr, cur_addr;
  logic [15:0] wr_data, word_cnt;
  logic        busy, done, sclk, mosi, cs_n;

  int checks = 0;
  int errors = 0;

  spi_stream_tx #(.DATA_W(16), .ADDR_W(8), .CLKS_PER_HALF_BIT(2), .GAP_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start_addr(start_addr), .end_addr(end_addr), .loop_en(loop_en), .start(start), .stop(stop),
    .busy(busy), .done(done), .cur_addr(cur_addr), .word_cnt(word_cnt),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          bits;
    int          len;
    int          t_start;
    int          t_end;
    logic [7:0]  addr;
  } frame_t;

  frame_t      frames[$];
  int          cyc = 0, done_cnt = 0, done_cyc = -1, busy_rise = -1;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [15:0] cap = '0;
  int          nbits = 0, t_fall = 0;

  // SPI monitor sampled mid-cycle: captures mosi on rising sclk inside each cs_n low window.
  always @(negedge clk) begin
    frame_t f;
    cyc++;
    if (prev_cs && !cs_n) begin cap = '0; nbits = 0; t_fall = cyc; end
    if (!cs_n && !prev_sclk && sclk) begin cap = {cap[14:0], mosi}; nbits++; end
    if (!prev_cs && cs_n) begin
      f.data = cap; f.bits = nbits; f.len = cyc - t_fall;
      f.t_start = t_fall; f.t_end = cyc; f.addr = cur_addr;
      frames.push_back(f);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!prev_busy && busy) busy_rise = cyc;
    prev_cs = cs_n; prev_sclk = sclk; prev_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] e, input logic l);
    tick();
    start_addr = s; end_addr = e; loop_en = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    do begin settle(); n++; end while (!done && n < limit);
    checks++;
    if (!done) begin errors++; $display("FAIL %s_done_timeout: no done within %0d cycles", name, limit); end
  endtask

  task automatic wait_frames(input int count, input int limit, input string name);
    int n = 0;
    while (frames.size() < count && n < limit) begin settle(); n++; end
    checks++;
    if (frames.size() < count) begin
      errors++; $display("FAIL %s_frame_timeout: got %0d frames, need %0d", name, frames.size(), count);
    end
  endtask

  task automatic wait_cs_low(input int limit, input string name);
    int n = 0;
    while (cs_n && n < limit) begin settle(); n++; end
    checks++;
    if (cs_n !== 1'b0) begin errors++; $display("FAIL %s_cs_timeout: cs_n=%b, need 0", name, cs_n); end
  endtask

  task automatic test_reset();
    int base, n;
    rst = 1'b1;
    repeat (3) tick();
    checks += 7;
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b need 0", done); end
    if (cur_addr !== 8'h0) begin errors++; $display("FAIL rst_cur_addr: got %h need 00", cur_addr); end
    if (word_cnt !== 16'h0) begin errors++; $display("FAIL rst_word_cnt: got %h need 0000", word_cnt); end
    if (sclk !== 1'b0)     begin errors++; $display("FAIL rst_sclk: got %b need 0", sclk); end
    if (mosi !== 1'b0)     begin errors++; $display("FAIL rst_mosi: got %b need 0", mosi); end
    if (cs_n !== 1'b1)     begin errors++; $display("FAIL rst_cs_n: got %b need 1", cs_n); end
    rst = 1'b0;
    tick();
    write_word(8'h10, 16'hA5C3);
    write_word(8'h11, 16'h0F0F);
    base = frames.size();
    launch(8'h10, 8'h11, 1'b0);
    wait_frames(base + 1, 400, "rst");
    wait_cs_low(200, "rst");
    n = 0;
    while (sclk !== 1'b1 && n < 10) begin settle(); n++; end
    rst = 1'b1;
    #1;
    checks += 5;
    if (cs_n !== 1'b1)      begin errors++; $display("FAIL midrst_cs_n: got %b need 1", cs_n); end
    if (sclk !== 1'b0)      begin errors++; $display("FAIL midrst_sclk: got %b need 0", sclk); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b need 0", busy); end
    if (word_cnt !== 16'h0) begin errors++; $display("FAIL midrst_word_cnt: got %h need 0000", word_cnt); end
    if (cur_addr !== 8'h0)  begin errors++; $display("FAIL midrst_cur_addr: got %h need 00", cur_addr); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int base = frames.size();
    int dbase = done_cnt;
    write_word(8'h10, 16'hA5C3);
    launch(8'h10, 8'h10, 1'b0);
    wait_done(400, "single");
    checks += 8;
    if (frames.size() - base != 1) begin errors++; $display("FAIL single_nframes: got %0d need 1", frames.size() - base); end
    else begin
      if (frames[base].data !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h need a5c3", frames[base].data); end
      if (frames[base].bits != 16) begin errors++; $display("FAIL single_bits: got %0d need 16", frames[base].bits); end
      if (frames[base].len != 64)  begin errors++; $display("FAIL single_cs_len: got %0d need 64", frames[base].len); end
    end
    if (done_cyc - busy_rise != 165) begin errors++; $display("FAIL single_done_time: got %0d need 165", done_cyc - busy_rise); end
    if (done_cnt - dbase != 1)   begin errors++; $display("FAIL single_done_cnt: got %0d need 1", done_cnt - dbase); end
    if (word_cnt !== 16'd1)      begin errors++; $display("FAIL single_word_cnt: got %0d need 1", word_cnt); end
    if (cur_addr !== 8'h10)      begin errors++; $display("FAIL single_cur_addr: got %h need 10", cur_addr); end
    settle();
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b need 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b need 0", busy); end
  endtask

  task automatic test_range();
    logic [15:0] exp_d [3] = '{16'h0002, 16'h0005, 16'h0008};
    int base, dbase;
    write_word(8'h00, 16'h0002);
    write_word(8'h01, 16'h0005);
    write_word(8'h02, 16'h0008);
    base = frames.size();
    dbase = done_cnt;
    launch(8'h00, 8'h02, 1'b0);
    // Retargeting and re-starting while busy must not disturb the run.
    start_addr = 8'h55; end_addr = 8'h66; loop_en = 1'b1; start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    wait_done(800, "range");
    checks++;
    if (frames.size() - base != 3) begin errors++; $display("FAIL range_nframes: got %0d need 3", frames.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (frames[base+i].data !== exp_d[i]) begin errors++; $display("FAIL range_data%0d: got %h need %h", i, frames[base+i].data, exp_d[i]); end
        if (frames[base+i].addr !== 8'(i)) begin errors++; $display("FAIL range_addr%0d: got %h need %h", i, frames[base+i].addr, 8'(i)); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (frames[base+i].t_start - frames[base+i-1].t_start != 165) begin
          errors++; $display("FAIL range_period%0d: got %0d need 165", i, frames[base+i].t_start - frames[base+i-1].t_start);
        end
      end
    end
    repeat (5) settle();
    checks += 3;
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL range_done_cnt: got %0d need 1", done_cnt - dbase); end
    if (word_cnt !== 16'd3)    begin errors++; $display("FAIL range_word_cnt: got %0d need 3", word_cnt); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL range_no_restart: busy %b need 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [15:0] exp_d [4] = '{16'h1111, 16'h2222, 16'h0002, 16'h0005};
    int base;
    write_word(8'hFE, 16'h1111);
    write_word(8'hFF, 16'h2222);
    base = frames.size();
    launch(8'hFE, 8'h01, 1'b0);
    wait_done(1000, "wrap");
    checks += 2;
    if (word_cnt !== 16'd4) begin errors++; $display("FAIL wrap_word_cnt: got %0d need 4", word_cnt); end
    if (frames.size() - base != 4) begin errors++; $display("FAIL wrap_nframes: got %0d need 4", frames.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (frames[base+i].addr !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h need %h", i, frames[base+i].addr, exp_a[i]); end
        if (frames[base+i].data !== exp_d[i]) begin errors++; $display("FAIL wrap_data%0d: got %h need %h", i, frames[base+i].data, exp_d[i]); end
      end
    end
  endtask

  task automatic test_start_stop_ignored();
    tick();
    start_addr = 8'h00; end_addr = 8'h00; loop_en = 1'b0; start = 1'b1; stop = 1'b1;
    repeat (4) tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL startstop_busy: got %b need 0", busy); end
    if (cs_n !== 1'b1) begin errors++; $display("FAIL startstop_cs_n: got %b need 1", cs_n); end
    start = 1'b0; stop = 1'b0;
    tick();
  endtask

  task automatic test_loop_stop();
    logic [7:0] exp_a [5] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    int base = frames.size();
    int dbase = done_cnt;
    launch(8'h00, 8'h01, 1'b1);
    wait_frames(base + 4, 1000, "loop");
    wait_cs_low(200, "loop");
    repeat (20) settle();
    stop = 1'b1;
    wait_done(400, "loop");
    stop = 1'b0;
    checks += 3;
    if (done_cnt - dbase != 1) begin errors++; $display("FAIL loop_done_cnt: got %0d need 1", done_cnt - dbase); end
    if (word_cnt !== 16'd5)    begin errors++; $display("FAIL loop_word_cnt: got %0d need 5", word_cnt); end
    if (frames.size() - base != 5) begin errors++; $display("FAIL loop_nframes: got %0d need 5", frames.size() - base); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks += 3;
        if (frames[base+i].addr !== exp_a[i]) begin errors++; $display("FAIL loop_addr%0d: got %h need %h", i, frames[base+i].addr, exp_a[i]); end
        if (frames[base+i].bits != 16) begin errors++; $display("FAIL loop_bits%0d: got %0d need 16", i, frames[base+i].bits); end
        if (frames[base+i].len != 64)  begin errors++; $display("FAIL loop_len%0d: got %0d need 64", i, frames[base+i].len); end
      end
      checks += 2;
      if (frames[base+4].data !== 16'h0002) begin errors++; $display("FAIL loop_last_data: got %h need 0002", frames[base+4].data); end
      if (done_cyc - frames[base+4].t_end != 100) begin
        errors++; $display("FAIL loop_gap_to_done: got %0d need 100", done_cyc - frames[base+4].t_end);
      end
    end
  endtask

  task automatic test_collision();
    int base;
    write_word(8'h20, 16'h1234);
    base = frames.size();
    tick();
    start_addr = 8'h20; end_addr = 8'h20; loop_en = 1'b1; start = 1'b1;
    tick();
    // This cycle is FETCH of 0x20: the write must not reach the frame being loaded.
    start = 1'b0; wr_en = 1'b1; wr_addr = 8'h20; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    wait_frames(base + 1, 400, "coll");
    wait_cs_low(200, "coll");
    stop = 1'b1;
    wait_done(400, "coll");
    stop = 1'b0;
    checks++;
    if (frames.size() - base != 2) begin errors++; $display("FAIL coll_nframes: got %0d need 2", frames.size() - base); end
    else begin
      checks += 2;
      if (frames[base].data !== 16'h1234)   begin errors++; $display("FAIL coll_old: got %h need 1234", frames[base].data); end
      if (frames[base+1].data !== 16'hBEEF) begin errors++; $display("FAIL coll_new: got %h need beef", frames[base+1].data); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start_addr = '0; end_addr = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    test_reset();
    test_single();
    test_range();
    test_wrap();
    test_start_stop_ignored();
    test_loop_stop();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
